// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone memory slave.
// State encodings and a constant log2 used for index and counter widths.
package wb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int CNT_W = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational address decode for the memory slave.
// Produces hit and word index from a raw bus address.
module wb_addr_decode
    import wb_pkg::*;
#(
    parameter int BASE_ADDRESS = 0,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_COUNT   = 16,
    parameter int AU_IN_DATA   = 1,
    parameter int IDX_W        = 4
) (
    input  logic [ADDR_WIDTH-1:0] adr,
    output logic                  hit,
    output logic [IDX_W-1:0]      idx
);

    localparam int SH = clog2(AU_IN_DATA);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDRESS);
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(AU_IN_DATA - 1);
    localparam logic [ADDR_WIDTH:0] CNT = (ADDR_WIDTH + 1)'(DATA_COUNT);

    logic [ADDR_WIDTH-1:0] off;
    logic [ADDR_WIDTH-1:0] word;
    logic                  above;
    logic                  aligned;
    logic                  in_range;

    assign off      = adr - BASE;
    assign word     = off >> SH;
    assign above    = (adr >= BASE);
    assign aligned  = ((off & LOW_MASK) == '0);
    assign in_range = ({1'b0, word} < CNT);
    assign hit      = above & aligned & in_range;
    assign idx      = word[IDX_W-1:0];

endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone classic single-port memory slave.
// Answers each cycle with one ack or err after WAIT_STATES extra cycles.
module wb_mem_slave
    import wb_pkg::*;
#(
    parameter int BASE_ADDRESS = 0,
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_COUNT   = 16,
    parameter int AU_IN_DATA   = 1,
    parameter int WAIT_STATES  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
    output logic                  err_o
);

    localparam int IDX_W = (DATA_COUNT > 1) ? clog2(DATA_COUNT) : 1;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   we_q;
    logic                   hit_q;
    logic [IDX_W-1:0]       idx_q;
    logic [DATA_WIDTH-1:0]  dat_q;
    logic [DATA_WIDTH-1:0]  mem [DATA_COUNT];

    logic                   dec_hit;
    logic [IDX_W-1:0]       dec_idx;
    logic                   req;

    logic                   go;
    logic                   r_we;
    logic                   r_hit;
    logic [IDX_W-1:0]       r_idx;
    logic [DATA_WIDTH-1:0]  r_dat;

    assign req = cyc_i & stb_i;

    wb_addr_decode #(
        .BASE_ADDRESS (BASE_ADDRESS),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .DATA_COUNT   (DATA_COUNT),
        .AU_IN_DATA   (AU_IN_DATA),
        .IDX_W        (IDX_W)
    ) u_dec (
        .adr (adr_i),
        .hit (dec_hit),
        .idx (dec_idx)
    );

    // Pick the transfer to answer this edge: live bus with no wait states, else latched
    always_comb begin
        go    = 1'b0;
        r_we  = we_q;
        r_hit = hit_q;
        r_idx = idx_q;
        r_dat = dat_q;
        case (state)
            S_IDLE: begin
                if (req && WAIT_STATES == 0) begin
                    go    = 1'b1;
                    r_we  = we_i;
                    r_hit = dec_hit;
                    r_idx = dec_idx;
                    r_dat = dat_i;
                end
            end
            S_WAIT: go = req && (cnt == '0);
            default: go = 1'b0;
        endcase
    end

    // Transfer FSM, memory array and registered response outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            we_q  <= 1'b0;
            hit_q <= 1'b0;
            idx_q <= '0;
            dat_q <= '0;
            ack_o <= 1'b0;
            err_o <= 1'b0;
            dat_o <= '0;
            for (int i = 0; i < DATA_COUNT; i++) mem[i] <= '0;
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            if (go) begin
                ack_o <= r_hit;
                err_o <= ~r_hit;
                if (r_hit && r_we) mem[r_idx] <= r_dat;
                if (!r_we) dat_o <= r_hit ? mem[r_idx] : '0;
            end
            unique case (state)
                S_IDLE: begin
                    if (req) begin
                        we_q  <= we_i;
                        hit_q <= dec_hit;
                        idx_q <= dec_idx;
                        dat_q <= dat_i;
                        if (WAIT_STATES > 0) begin
                            cnt   <= CNT_W'(WAIT_STATES - 1);
                            state <= S_WAIT;
                        end else begin
                            state <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    if (!req) state <= S_IDLE;
                    else if (cnt == '0) state <= S_RESP;
                    else cnt <= cnt - 1'b1;
                end
                S_RESP: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Flag a corrupted state encoding in simulation
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (state inside {S_IDLE, S_WAIT, S_RESP})
            else $error("wb_mem_slave: illegal state %0d", state);
        end
    end

endmodule

// File: tb/tb_wb_mem_slave.sv
// Directed bench for wb_mem_slave across four parameter sets.
// Inputs driven on falling edges, outputs sampled on falling edges.
module tb_wb_mem_slave;

    logic        clk;
    logic        rst;
    logic        cyc   [4];
    logic        stb   [4];
    logic        we    [4];
    logic [15:0] dat_i [4];
    logic [15:0] adr   [4];
    logic [15:0] dat_o [4];
    logic        ack   [4];
    logic        err   [4];

    int n_chk;
    int n_fail;

    wb_mem_slave u0 (
        .clk(clk), .rst(rst), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]),
        .dat_i(dat_i[0]), .adr_i(adr[0]), .dat_o(dat_o[0]),
        .ack_o(ack[0]), .err_o(err[0])
    );

    wb_mem_slave #(.WAIT_STATES(3)) u1 (
        .clk(clk), .rst(rst), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]),
        .dat_i(dat_i[1]), .adr_i(adr[1]), .dat_o(dat_o[1]),
        .ack_o(ack[1]), .err_o(err[1])
    );

    wb_mem_slave #(.BASE_ADDRESS(16'h0100), .AU_IN_DATA(4)) u2 (
        .clk(clk), .rst(rst), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we[2]),
        .dat_i(dat_i[2]), .adr_i(adr[2]), .dat_o(dat_o[2]),
        .ack_o(ack[2]), .err_o(err[2])
    );

    wb_mem_slave #(.WAIT_STATES(2)) u3 (
        .clk(clk), .rst(rst), .cyc_i(cyc[3]), .stb_i(stb[3]), .we_i(we[3]),
        .dat_i(dat_i[3]), .adr_i(adr[3]), .dat_o(dat_o[3]),
        .ack_o(ack[3]), .err_o(err[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xfer(input int u, input logic w, input logic [15:0] a,
                        input logic [15:0] d, output logic [15:0] rd,
                        output logic ak, output logic er, output int lat);
        int n;
        n  = 0;
        ak = 1'b0;
        er = 1'b0;
        @(negedge clk);
        cyc[u] = 1'b1;
        stb[u] = 1'b1;
        we[u] = w;
        adr[u] = a;
        dat_i[u] = d;
        while (n < 40 && !ak && !er) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            ak = ack[u];
            er = err[u];
        end
        rd  = dat_o[u];
        lat = (ak | er) ? n : -1;
        cyc[u] = 1'b0;
        stb[u] = 1'b0;
        we[u] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("single_cycle_resp", {30'd0, ack[u], err[u]}, 32'd0);
    endtask

    logic [15:0] rd;
    logic        ak;
    logic        er;
    int          lat;
    int          acks;
    int          errs;
    logic        seen;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc[i] = 1'b0;
            stb[i] = 1'b0;
            we[i] = 1'b0;
            dat_i[i] = '0;
            adr[i] = '0;
        end
        repeat (3) @(negedge clk);
        check("reset_ack", {31'd0, ack[0]}, 32'd0);
        check("reset_err", {31'd0, err[0]}, 32'd0);
        check("reset_dat", {16'd0, dat_o[0]}, 32'd0);
        rst = 1'b1;

        // basic write then read, zero wait states
        xfer(0, 1'b1, 16'd3, 16'h3333, rd, ak, er, lat);
        check("w3_ack", {31'd0, ak}, 32'd1);
        check("w3_lat", lat, 32'd1);
        xfer(0, 1'b0, 16'd3, 16'h0000, rd, ak, er, lat);
        check("r3_ack", {31'd0, ak}, 32'd1);
        check("r3_lat", lat, 32'd1);
        check("r3_dat", {16'd0, rd}, 32'h3333);

        // full sweep of words 0..15
        acks = 0;
        errs = 0;
        for (int i = 0; i < 16; i++) begin
            xfer(0, 1'b1, 16'(i), 16'(i * 16'h1111), rd, ak, er, lat);
            acks += int'(ak);
            errs += int'(er);
        end
        for (int i = 0; i < 16; i++) begin
            xfer(0, 1'b0, 16'(i), 16'h0000, rd, ak, er, lat);
            acks += int'(ak);
            errs += int'(er);
            check("sweep_rd", {16'd0, rd}, 32'(i * 16'h1111));
        end
        check("sweep_acks", acks, 32'd32);
        check("sweep_errs", errs, 32'd0);

        // three wait states: ack on the fourth edge, memory untouched before it
        @(negedge clk);
        cyc[1] = 1'b1;
        stb[1] = 1'b1;
        we[1] = 1'b1;
        adr[1] = 16'd5;
        dat_i[1] = 16'h5A5A;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k < 4) begin
                check("ws3_early_ack", {31'd0, ack[1]}, 32'd0);
                check("ws3_mem_pre", {16'd0, u1.mem[5]}, 32'd0);
            end else begin
                check("ws3_ack", {31'd0, ack[1]}, 32'd1);
                check("ws3_mem_post", {16'd0, u1.mem[5]}, 32'h5A5A);
            end
        end
        cyc[1] = 1'b0;
        stb[1] = 1'b0;
        we[1] = 1'b0;
        xfer(1, 1'b0, 16'd5, 16'h0000, rd, ak, er, lat);
        check("ws3_rd_lat", lat, 32'd4);
        check("ws3_rd_dat", {16'd0, rd}, 32'h5A5A);

        // base 0x100, stride 4
        xfer(2, 1'b1, 16'h013C, 16'hC0DE, rd, ak, er, lat);
        check("b_w13c_ack", {30'd0, ak, er}, 32'd2);
        xfer(2, 1'b0, 16'h013C, 16'h0000, rd, ak, er, lat);
        check("b_r13c_dat", {16'd0, rd}, 32'hC0DE);
        xfer(2, 1'b0, 16'h00FC, 16'h0000, rd, ak, er, lat);
        check("b_r0fc_resp", {30'd0, ak, er}, 32'd1);
        check("b_r0fc_dat", {16'd0, rd}, 32'd0);
        xfer(2, 1'b0, 16'h013C, 16'h0000, rd, ak, er, lat);
        xfer(2, 1'b0, 16'h0102, 16'h0000, rd, ak, er, lat);
        check("b_r102_resp", {30'd0, ak, er}, 32'd1);
        check("b_r102_dat", {16'd0, rd}, 32'd0);
        xfer(2, 1'b0, 16'h013C, 16'h0000, rd, ak, er, lat);
        xfer(2, 1'b0, 16'h0140, 16'h0000, rd, ak, er, lat);
        check("b_r140_resp", {30'd0, ak, er}, 32'd1);
        check("b_r140_dat", {16'd0, rd}, 32'd0);
        xfer(2, 1'b0, 16'h0100, 16'h0000, rd, ak, er, lat);
        check("b_r100_resp", {30'd0, ak, er}, 32'd2);

        // abort during wait states
        xfer(3, 1'b1, 16'd7, 16'hAAAA, rd, ak, er, lat);
        check("ab_w_lat", lat, 32'd3);
        @(negedge clk);
        cyc[3] = 1'b1;
        stb[3] = 1'b1;
        we[3] = 1'b1;
        adr[3] = 16'd7;
        dat_i[3] = 16'h5555;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        cyc[3] = 1'b0;
        stb[3] = 1'b0;
        we[3] = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            seen = seen | ack[3] | err[3];
        end
        check("ab_no_resp", {31'd0, seen}, 32'd0);
        xfer(3, 1'b0, 16'd7, 16'h0000, rd, ak, er, lat);
        check("ab_rd_dat", {16'd0, rd}, 32'hAAAA);

        // reset in the middle of a waited write
        xfer(3, 1'b1, 16'd9, 16'h1234, rd, ak, er, lat);
        xfer(3, 1'b0, 16'd9, 16'h0000, rd, ak, er, lat);
        check("rs_pre_dat", {16'd0, rd}, 32'h1234);
        @(negedge clk);
        cyc[3] = 1'b1;
        stb[3] = 1'b1;
        we[3] = 1'b1;
        adr[3] = 16'd9;
        dat_i[3] = 16'hBEEF;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rs_ack", {31'd0, ack[3]}, 32'd0);
        check("rs_err", {31'd0, err[3]}, 32'd0);
        check("rs_dat", {16'd0, dat_o[3]}, 32'd0);
        @(negedge clk);
        cyc[3] = 1'b0;
        stb[3] = 1'b0;
        we[3] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        xfer(3, 1'b0, 16'd9, 16'h0000, rd, ak, er, lat);
        check("rs_rd_ack", {31'd0, ak}, 32'd1);
        check("rs_rd_dat", {16'd0, rd}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
